hilo_div_ctrl: RTL and testbench
================================

Name: hilo_div_ctrl

Overview:
- Sequencer and HI/LO register bank sitting directly downstream of the multicycle divider.
- Accepts a DIV request from the control unit and latches the operands.
- Clears the divider, then drives its enable for a fixed number of cycles and captures quotient/remainder into architectural LO/HI.
- Serves MFHI/MFLO/MTHI/MTLO, stalls the pipeline while a divide is in flight, and raises the divide-by-zero exception.

Parameters:
- DIV_CYCLES, 34, number of cycles div_en is held high before the result is sampled (divider needs 33; one cycle margin).
- CNT_W, 6, width of the run counter; must satisfy 2^CNT_W > DIV_CYCLES.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a divide of op_a / op_b
- op_a  input  32  dividend, sampled when start is accepted
- op_b  input  32  divisor, sampled when start is accepted
- mthi  input  1  write wdata to HI
- mtlo  input  1  write wdata to LO
- wdata  input  32  data for mthi/mtlo
- mfhi  input  1  read-request for HI
- mflo  input  1  read-request for LO
- rdata  output  32  HI or LO per mfhi/mflo, else 0
- stall  output  1  pipeline must hold this cycle
- busy  output  1  divide in flight
- done  output  1  one-cycle pulse when the divide completes
- exc_div0  output  1  one-cycle pulse, divisor was zero
- div_clr  output  1  divider clear, drives the divider reset
- div_en  output  1  divider step enable (control)
- div_a  output  32  latched dividend to divider
- div_b  output  32  latched divisor to divider
- div_quo  input  32  divider quotient
- div_rem  input  32  divider remainder
- div_zero  input  1  divider zero-divisor flag
- hi  output  32  architectural HI (remainder)
- lo  output  32  architectural LO (quotient)

Behaviour:
- Reset values:
  - all outputs 0, hi = lo = 0, state IDLE, counter 0.
  - div_clr = 1 during reset.
  - Reset mid-operation aborts the divide with no done and no exc_div0.
- FSM states: IDLE, CLR, RUN, CAPT.
- IDLE:
  - start = 1 is accepted: latch op_a/op_b into div_a/div_b, busy = 1, go to CLR.
  - start is ignored if mthi/mtlo is asserted in the same cycle. The mt* write wins, start is refused and stall = 1.
- CLR:
  - div_clr = 1, div_en = 0, counter cleared, go to RUN.
- RUN:
  - div_en = 1; counter increments each cycle.
  - When counter == DIV_CYCLES-1, go to CAPT.
  - div_a/div_b are held constant throughout.
- CAPT:
  - div_en = 0, done = 1.
  - If div_zero = 1 or latched div_b == 0: exc_div0 = 1, hi/lo unchanged.
  - Else hi <= div_rem and lo <= div_quo, visible the next cycle.
  - busy drops the next cycle; return to IDLE.
- Latency: start accepted at cycle T gives done at T+DIV_CYCLES+2 and new hi/lo at T+DIV_CYCLES+3. Result values are signed per the divider, taken unmodified.
- busy = 1 in CLR, RUN and CAPT.
- stall = busy & (start | mfhi | mflo | mthi | mtlo). While stalled:
  - no register write occurs;
  - a new start is not accepted;
  - rdata = 0.
- mthi/mtlo in IDLE without stall: write on the clock edge. Both asserted together write both registers.
- mfhi/mflo:
  - Combinational rdata from the current hi/lo when not stalled.
  - mfhi has priority if both are asserted.
- The divider outputs are only sampled in CAPT; values in other states are ignored.

Optional Feature:
- Macro HILO_DIV_FWD_EN.
- Defined:
  - In CAPT, mfhi/mflo are not stalled. rdata is forwarded from div_rem/div_quo, or from current hi/lo when the div-by-zero condition holds.
  - stall excludes mfhi/mflo in CAPT, saving one cycle.
- Undefined: mfhi/mflo stall through CAPT and read the updated register in IDLE.

Test Plan:
- Basic divide: op_a = 100, op_b = 7, start -> done at T+36, then lo = 14, hi = 2, exc_div0 = 0.
- Signed divide: op_a = -100 (0xFFFFFF9C), op_b = 7 -> lo/hi equal the divider outputs sampled in CAPT; div_a/div_b stable for the whole RUN.
- Divide by zero: hi = lo = 0x12345678 preset via mthi/mtlo, then op_b = 0 -> exc_div0 and done pulse together, hi/lo remain 0x12345678.
- Read while busy: mflo asserted 3 cycles after start:
  - stall = 1 until CAPT, with HILO_DIV_FWD_EN undefined held until IDLE;
  - then rdata = 14 (100/7 case).
- Write/start collision and write while busy:
  - mthi with wdata = 0xDEADBEEF and start in the same IDLE cycle -> hi = 0xDEADBEEF, start refused, state remains IDLE;
  - mtlo during RUN -> stall = 1, lo unchanged.
- Reset mid-RUN (cycle 10): next cycle all outputs 0, hi = lo = 0, state IDLE, no done pulse; a new start runs normally.

Source files
------------

// File: rtl/hilo_div_ctrl_if.sv
// Bus between the control unit, the multicycle divider and the HI/LO sequencer.
// The slave modport is the sequencer. The master modport is the pipeline/divider side.
interface hilo_div_ctrl_if;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        mfhi;
  logic        mflo;
  logic [31:0] rdata;
  logic        stall;
  logic        busy;
  logic        done;
  logic        exc_div0;
  logic        div_clr;
  logic        div_en;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport slave (
    input  start, op_a, op_b, mthi, mtlo, wdata, mfhi, mflo,
    input  div_quo, div_rem, div_zero,
    output rdata, stall, busy, done, exc_div0,
    output div_clr, div_en, div_a, div_b, hi, lo
  );

  modport master (
    output start, op_a, op_b, mthi, mtlo, wdata, mfhi, mflo,
    output div_quo, div_rem, div_zero,
    input  rdata, stall, busy, done, exc_div0,
    input  div_clr, div_en, div_a, div_b, hi, lo
  );
endinterface

// File: rtl/hilo_div_ctrl.sv
// HI/LO register bank and divide sequencer in front of the multicycle divider.
// Define HILO_DIV_FWD_EN to forward the divider result to MFHI/MFLO during CAPT.
module hilo_div_ctrl #(
  parameter int DIV_CYCLES = 34,
  parameter int CNT_W      = 6
) (
  input logic             clk,
  input logic             reset,
  hilo_div_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CLR, RUN, CAPT} state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        divA_q, divA_d;
  logic [31:0]        divB_q, divB_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  logic               div0Cond;
  logic               busyInt;
  logic               stallInt;
  logic               rdReq;
  logic               fwdSel;
  logic [31:0]        hiRead;
  logic [31:0]        loRead;

  assign div0Cond = bus.div_zero || (divB_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      divA_q  <= '0;
      divB_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      divA_q  <= divA_d;
      divB_q  <= divB_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // An mt* write in IDLE always wins over a simultaneous start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    divA_d  = divA_q;
    divB_d  = divB_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.mthi) hi_d = bus.wdata;
        if (bus.mtlo) lo_d = bus.wdata;
        if (bus.start && !bus.mthi && !bus.mtlo) begin
          divA_d  = bus.op_a;
          divB_d  = bus.op_b;
          state_d = CLR;
        end
      end
      CLR: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = CAPT;
      end
      CAPT: begin
        if (!div0Cond) begin
          hi_d = bus.div_rem;
          lo_d = bus.div_quo;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control outputs are forced quiet while reset is held, except div_clr.
  always_comb begin
    busyInt = (state_q != IDLE);
    rdReq   = bus.mfhi || bus.mflo;
    fwdSel  = 1'b0;
`ifdef HILO_DIV_FWD_EN
    if (state_q == CAPT) rdReq = 1'b0;
    fwdSel = (state_q == CAPT) && !div0Cond;
`endif
    hiRead = fwdSel ? bus.div_rem : hi_q;
    loRead = fwdSel ? bus.div_quo : lo_q;

    stallInt = !reset &&
               ((busyInt && (bus.start || bus.mthi || bus.mtlo || rdReq)) ||
                ((state_q == IDLE) && bus.start && (bus.mthi || bus.mtlo)));

    bus.rdata = '0;
    if (!reset && !stallInt) begin
      if (bus.mfhi)      bus.rdata = hiRead;
      else if (bus.mflo) bus.rdata = loRead;
    end

    bus.stall    = stallInt;
    bus.busy     = !reset && busyInt;
    bus.done     = !reset && (state_q == CAPT);
    bus.exc_div0 = !reset && (state_q == CAPT) && div0Cond;
    bus.div_clr  = reset || (state_q == CLR);
    bus.div_en   = !reset && (state_q == RUN);
    bus.div_a    = divA_q;
    bus.div_b    = divB_q;
    bus.hi       = hi_q;
    bus.lo       = lo_q;
  end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Self-checking bench for hilo_div_ctrl with a behavioural divider model.
// Builds with or without HILO_DIV_FWD_EN.
module tb_hilo_div_ctrl;

  logic clk;
  logic reset;
  int   checkCount;
  int   passCount;

  hilo_div_ctrl_if bus();

  hilo_div_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider model: results become valid only after 33 enabled steps since the last clear.
  int modelCnt;
  logic signed [31:0] sA, sB;
  always @(posedge clk) begin
    if (bus.div_clr) modelCnt <= 0;
    else if (bus.div_en && modelCnt < 60) modelCnt <= modelCnt + 1;
  end

  always_comb begin
    sA = bus.div_a;
    sB = bus.div_b;
    bus.div_zero = 1'b0;
    if (modelCnt >= 33 && sB != 0) begin
      bus.div_quo = sA / sB;
      bus.div_rem = sA % sB;
    end else if (modelCnt >= 33) begin
      bus.div_quo  = 32'hFFFFFFFF;
      bus.div_rem  = bus.div_a;
      bus.div_zero = 1'b1;
    end else begin
      bus.div_quo = 32'hBAD0BAD0;
      bus.div_rem = 32'h0BAD0BAD;
    end
  end

  typedef struct {
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        mfhi;
    logic        mflo;
    logic [31:0] expRdata;
    logic        expStall;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    else passCount++;
  endtask

  task automatic clearInputs();
    bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;
    bus.mfhi = 1'b0; bus.mflo = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    bus.mthi = v.mthi; bus.mtlo = v.mtlo; bus.wdata = v.wdata;
    bus.mfhi = v.mfhi; bus.mflo = v.mflo;
    #1;
    checkOutput("vecRdata", bus.rdata, v.expRdata);
    checkOutput("vecStall", 32'(bus.stall), 32'(v.expStall));
    @(posedge clk); #1;
    checkOutput("vecHi", bus.hi, v.expHi);
    checkOutput("vecLo", bus.lo, v.expLo);
    clearInputs();
  endtask

  // Starts a divide and follows it cycle by cycle until busy drops.
  task automatic runDivide(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] expHi, input logic [31:0] expLo, input bit expExc);
    int doneCyc, excCyc, idleCyc, enCount;
    bit opsStable;
    doneCyc = -1; excCyc = -1; idleCyc = -1; enCount = 0; opsStable = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = a; bus.op_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op_a = 32'hA5A5A5A5; bus.op_b = 32'h5A5A5A5A;
    for (int k = 1; k <= 45; k++) begin
      if (bus.done && doneCyc < 0) doneCyc = k;
      if (bus.exc_div0 && excCyc < 0) excCyc = k;
      if (bus.div_en) begin
        enCount++;
        if (bus.div_a !== a || bus.div_b !== b) opsStable = 1'b0;
      end
      if (!bus.busy) begin
        idleCyc = k;
        break;
      end
      @(posedge clk); #1;
    end
    clearInputs();
    checkOutput("doneCycle", 32'(doneCyc), 32'd36);
    checkOutput("excCycle", 32'(excCyc), expExc ? 32'd36 : 32'hFFFFFFFF);
    checkOutput("busyDropCycle", 32'(idleCyc), 32'd37);
    checkOutput("enCycles", 32'(enCount), 32'd34);
    checkOutput("opsStable", 32'(opsStable), 32'd1);
    checkOutput("divHi", bus.hi, expHi);
    checkOutput("divLo", bus.lo, expLo);
  endtask

  task automatic waitIdle(input string name);
    int k;
    for (k = 0; k < 50 && bus.busy; k++) begin
      @(posedge clk); #1;
    end
    checkOutput(name, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int relCyc, doneSeen;
    logic [31:0] relData;
    checkCount = 0;
    passCount  = 0;
    reset = 1'b1;
    clearInputs();

    vecs[0] = '{1'b1, 1'b0, 32'h11111111, 1'b0, 1'b0, 32'h0,         1'b0, 32'h11111111, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 32'h22222222, 1'b0, 1'b0, 32'h0,         1'b0, 32'h11111111, 32'h22222222};
    vecs[2] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h11111111,  1'b0, 32'h11111111, 32'h22222222};
    vecs[3] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h22222222,  1'b0, 32'h11111111, 32'h22222222};
    vecs[4] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h11111111,  1'b0, 32'h11111111, 32'h22222222};
    vecs[5] = '{1'b1, 1'b1, 32'h12345678, 1'b0, 1'b0, 32'h0,         1'b0, 32'h12345678, 32'h12345678};
    vecs[6] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h12345678,  1'b0, 32'h12345678, 32'h12345678};
    vecs[7] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,         1'b0, 32'h12345678, 32'h12345678};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("divClrInReset", 32'(bus.div_clr), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("rstCtrl", {26'd0, bus.busy, bus.stall, bus.done, bus.exc_div0, bus.div_clr, bus.div_en}, 32'd0);
    checkOutput("rstHi", bus.hi, 32'd0);
    checkOutput("rstLo", bus.lo, 32'd0);
    checkOutput("rstDivA", bus.div_a, 32'd0);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    runDivide(32'd5, 32'd0, 32'h12345678, 32'h12345678, 1'b1);
    runDivide(32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    runDivide(32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0);

    // Read while busy: mflo held from cycle T+3 until the stall releases.
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = 32'd100; bus.op_b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    relCyc = -1; relData = '0;
    for (int k = 1; k <= 45; k++) begin
      if (k >= 3) bus.mflo = 1'b1;
      #1;
      if (k == 3) begin
        checkOutput("rdStallEarly", 32'(bus.stall), 32'd1);
        checkOutput("rdDataStalled", bus.rdata, 32'd0);
      end
      if (k >= 3 && !bus.stall) begin
        relCyc = k;
        relData = bus.rdata;
        break;
      end
      @(posedge clk); #1;
    end
    bus.mflo = 1'b0;
`ifdef HILO_DIV_FWD_EN
    checkOutput("rdReleaseCycle", 32'(relCyc), 32'd36);
`else
    checkOutput("rdReleaseCycle", 32'(relCyc), 32'd37);
`endif
    checkOutput("rdReleaseData", relData, 32'd14);
    waitIdle("rdIdleTimeout");

    // Write/start collision in IDLE.
    @(negedge clk);
    bus.mthi = 1'b1; bus.wdata = 32'hDEADBEEF;
    bus.start = 1'b1; bus.op_a = 32'd100; bus.op_b = 32'd7;
    #1;
    checkOutput("collStall", 32'(bus.stall), 32'd1);
    @(posedge clk); #1;
    clearInputs();
    checkOutput("collHi", bus.hi, 32'hDEADBEEF);
    checkOutput("collBusy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    checkOutput("collNoClr", {30'd0, bus.div_clr, bus.busy}, 32'd0);

    // mtlo during RUN is refused.
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = 32'd1000; bus.op_b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.mtlo = 1'b1; bus.wdata = 32'h55555555;
    #1;
    checkOutput("mtloRunStall", 32'(bus.stall), 32'd1);
    @(posedge clk); #1;
    bus.mtlo = 1'b0;
    checkOutput("mtloRunLo", bus.lo, 32'd14);
    waitIdle("mtloIdleTimeout");
    checkOutput("mtloRunResLo", bus.lo, 32'd142);
    checkOutput("mtloRunResHi", bus.hi, 32'd6);

    // Reset at cycle T+10 aborts the divide.
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = 32'd100; bus.op_b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checkOutput("preRstEn", 32'(bus.div_en), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("midRstClr", 32'(bus.div_clr), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checkOutput("postRstCtrl", {26'd0, bus.busy, bus.stall, bus.done, bus.exc_div0, bus.div_clr, bus.div_en}, 32'd0);
    checkOutput("postRstHiLo", bus.hi | bus.lo, 32'd0);
    checkOutput("postRstDivAB", bus.div_a | bus.div_b, 32'd0);
    doneSeen = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done || bus.exc_div0) doneSeen++;
      @(posedge clk); #1;
    end
    checkOutput("postRstNoDone", 32'(doneSeen), 32'd0);
    runDivide(32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
